tdpr_arbiter: RTL
=================

Name: tdpr_arbiter

Overview:
- Shares the two ports of the true dual-port RAM among N requesters.
- Each cycle, a round-robin arbiter picks up to two requests, one for port A and one for port B.
- It drives the RAM port pins, suppresses unsafe same-address conflicts, and routes the registered RAM read data back to the requester that issued the read.
- It sits directly between the requesters and the true dual-port RAM instance.

Parameters:
- N, 4, number of requesters (2..8).
- ADDR_SIZE, 8, RAM address width.
- DATA_SIZE, 8, RAM data width.
- CNT_SIZE, 16, width of the collision counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester request; held stable until granted.
- we  in  N  per-requester write enable (1 = write, 0 = read).
- addr  in  N*ADDR_SIZE  packed addresses; requester i uses slice [i*ADDR_SIZE +: ADDR_SIZE].
- wdata  in  N*DATA_SIZE  packed write data.
- gnt  out  N  one-hot-per-port grant; at most 2 bits set; a grant accepts the request in that cycle.
- rvalid  out  N  read data valid, one cycle after the read grant.
- rdata  out  N*DATA_SIZE  packed read data; slice i is valid when rvalid[i]=1, otherwise 0.
- ram_en_a, ram_we_a  out  1  RAM port A enable and write enable.
- ram_addr_a  out  ADDR_SIZE  RAM port A address.
- ram_din_a  out  DATA_SIZE  RAM port A write data.
- ram_dout_a  in  DATA_SIZE  RAM port A registered read data.
- ram_en_b, ram_we_b, ram_addr_b, ram_din_b, ram_dout_b: same as port A, for port B.
- coll_cnt  out  CNT_SIZE  saturating count of suppressed collisions.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ptr=0, rvalid=0, owner registers=0, coll_cnt=0.
  - gnt=0 and ram_en_a/b=0, forced combinationally while rst_n=0.
- Arbitration is combinational within a cycle:
  - Port A winner: the first i with req[i]=1, scanning ptr, ptr+1, ... mod N.
  - Port B winner: the next requesting index after the A winner in the same scan.
  - No second requester: port B is idle.
- Collision rule:
  - Applies when both winners have the same addr and at least one of them has we=1.
  - The B grant is suppressed that cycle and ram_en_b=0.
  - coll_cnt increments by 1, saturating at all-ones.
  - Read/read to the same address is allowed; both are granted.
- RAM drive:
  - ram_en_x=1 only when port x has a granted requester.
  - ram_we_x, ram_addr_x, ram_din_x are muxed from that requester.
  - When ram_en_x=0, these signals are driven 0.
- gnt[i]=1 for each granted index; the RAM samples the access on the same rising edge.
- Pointer update at the clock edge:
  - ptr <= (highest-order granted index in scan order, i.e. B's if granted, else A's) + 1, mod N.
  - No grant: ptr unchanged.
- Read return:
  - On an edge where port x granted a read (we=0) to requester i, register owner_x=i and a valid flag.
  - In the next cycle, rvalid[i]=1 and rdata slice i = ram_dout_x.
  - Writes produce no rvalid.
  - Back-to-back reads by the same requester give rvalid high on consecutive cycles.
- Simultaneous A and B reads by different requesters: both rvalid bits are set in the same cycle.
- A requester can win at most one port per cycle, because the B scan excludes the A winner.
- A requester must keep req and its fields stable until gnt. Dropping req before grant is legal; the request is simply not issued.
- Reset asserted mid-operation: a pending rvalid is discarded, and after reset release no stale rvalid appears.
- Read latency: 1 cycle from gnt to rvalid. Throughput: up to 2 accesses per cycle.

Decomposition:
- Shared package tdpr_pkg:
  - Default ADDR_SIZE and DATA_SIZE constants.
  - A port-select localparam (PORT_A=0, PORT_B=1).
  - A function for the round-robin index increment mod N.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: req vector, start index, exclude mask.
  - Outputs: found flag and winner index.
  - Instantiated twice, once for port A and once for port B (B excludes the A winner).

Test Plan:
1. Reset, then req=4'b0001, we=0, addr0=8'h10, RAM preloaded 8'h10=8'hAA: gnt=0001, ram_en_a=1, ram_addr_a=8'h10, ram_en_b=0; next cycle rvalid=0001, rdata0=8'hAA; ptr=1.
2. All four requesting reads with ptr=0, addresses distinct: cycle 1 grants {0,1}, ptr=2; cycle 2 grants {2,3}, ptr=0; each rvalid arrives one cycle after its grant with its own data.
3. req0 write 8'h20 <= 8'h55 and req1 read 8'h20, ptr=0: only gnt0 is granted, coll_cnt=1. Next cycle gnt1 is granted on port A and reads 8'h55.
4. req2 and req3 both read 8'h30, ptr=2: both granted, no collision, coll_cnt unchanged, rvalid=1100 in the same cycle.
5. rst_n pulsed low mid-cycle right after a read grant: rvalid, gnt and ram_en drop immediately, and no rvalid appears after release.
6. 2^CNT_SIZE+5 forced collisions: coll_cnt saturates at all-ones and does not wrap.

Source files
------------

// File: rtl/tdpr_arbiter_pkg.sv
// Shared constants and helpers for the true dual-port RAM arbiter.
// Port indices select per-port arrays; rr_inc advances a round-robin index.
package tdpr_pkg;

    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_DATA_SIZE = 8;
    localparam int PORT_A        = 0;
    localparam int PORT_B        = 1;

    function automatic int rr_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/tdpr_arbiter_if.sv
// Requester-side bus of the arbiter: packed per-requester request fields,
// grants and read-return data.
interface tdpr_arbiter_if
    import tdpr_pkg::*;
#(
    parameter int N         = 4,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE
);
    logic [N-1:0]           req;
    logic [N-1:0]           we;
    logic [N*ADDR_SIZE-1:0] addr;
    logic [N*DATA_SIZE-1:0] wdata;
    logic [N-1:0]           gnt;
    logic [N-1:0]           rvalid;
    logic [N*DATA_SIZE-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/tdpr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after start
// (wrapping mod N) that is not masked out by excl.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic          found,
    output logic [IW-1:0] idx
);
    int j;

    // Wrapping scan from start; the first eligible index wins.
    always_comb begin
        found = 1'b0;
        idx   = {IW{1'b0}};
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            j = (j >= N) ? (j - N) : j;
            if (!found && req[j] && !excl[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end else begin
                found = found;
            end
        end
    end
endmodule

// File: rtl/tdpr_arbiter.sv
// Round-robin arbiter sharing both ports of a true dual-port RAM among N
// requesters, with same-address conflict suppression and read-data return.
module tdpr_arbiter
    import tdpr_pkg::*;
#(
    parameter int N         = 4,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdpr_arbiter_if.slave        bus,
    output logic                 ram_en_a,
    output logic                 ram_we_a,
    output logic [ADDR_SIZE-1:0] ram_addr_a,
    output logic [DATA_SIZE-1:0] ram_din_a,
    input  logic [DATA_SIZE-1:0] ram_dout_a,
    output logic                 ram_en_b,
    output logic                 ram_we_b,
    output logic [ADDR_SIZE-1:0] ram_addr_b,
    output logic [DATA_SIZE-1:0] ram_din_b,
    input  logic [DATA_SIZE-1:0] ram_dout_b,
    output logic [CNT_SIZE-1:0]  coll_cnt
);
    localparam int IW = $clog2(N);
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);
    localparam logic [CNT_SIZE-1:0] CNT_MAX = {CNT_SIZE{1'b1}};

    logic [IW-1:0]        ptr_r;
    logic [1:0]           found_s;
    logic [1:0]           grant_s;
    logic [IW-1:0]        win_s [2];
    logic [N-1:0]         excl_s;
    logic                 coll_s;
    logic [ADDR_SIZE-1:0] win_addr_s [2];
    logic [DATA_SIZE-1:0] win_data_s [2];
    logic [1:0]           win_we_s;
    logic [1:0]           rd_vld_r;
    logic [IW-1:0]        owner_r [2];
    logic [CNT_SIZE-1:0]  coll_cnt_r;

    // B scans from the same pointer but skips A's winner, so it lands on the next requester.
    assign excl_s = found_s[PORT_A] ? (N'(1) << win_s[PORT_A]) : {N{1'b0}};

    rr_pick #(.N(N), .IW(IW)) u_pick_a (
        .req(bus.req), .start(ptr_r), .excl({N{1'b0}}),
        .found(found_s[PORT_A]), .idx(win_s[PORT_A])
    );

    rr_pick #(.N(N), .IW(IW)) u_pick_b (
        .req(bus.req), .start(ptr_r), .excl(excl_s),
        .found(found_s[PORT_B]), .idx(win_s[PORT_B])
    );

    // Mux winner fields, apply the collision rule and drive grants and RAM pins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            win_addr_s[p] = bus.addr[win_s[p]*ADDR_SIZE +: ADDR_SIZE];
            win_data_s[p] = bus.wdata[win_s[p]*DATA_SIZE +: DATA_SIZE];
            win_we_s[p]   = bus.we[win_s[p]];
        end
        coll_s = found_s[PORT_A] && found_s[PORT_B] &&
                 (win_addr_s[PORT_A] == win_addr_s[PORT_B]) &&
                 (win_we_s[PORT_A] || win_we_s[PORT_B]);
        grant_s[PORT_A] = rst_n && found_s[PORT_A];
        grant_s[PORT_B] = rst_n && found_s[PORT_B] && !coll_s;
        bus.gnt = ({N{grant_s[PORT_A]}} & (N'(1) << win_s[PORT_A])) |
                  ({N{grant_s[PORT_B]}} & (N'(1) << win_s[PORT_B]));
        ram_en_a   = grant_s[PORT_A];
        ram_we_a   = grant_s[PORT_A] && win_we_s[PORT_A];
        ram_addr_a = grant_s[PORT_A] ? win_addr_s[PORT_A] : {ADDR_SIZE{1'b0}};
        ram_din_a  = grant_s[PORT_A] ? win_data_s[PORT_A] : {DATA_SIZE{1'b0}};
        ram_en_b   = grant_s[PORT_B];
        ram_we_b   = grant_s[PORT_B] && win_we_s[PORT_B];
        ram_addr_b = grant_s[PORT_B] ? win_addr_s[PORT_B] : {ADDR_SIZE{1'b0}};
        ram_din_b  = grant_s[PORT_B] ? win_data_s[PORT_B] : {DATA_SIZE{1'b0}};
    end

    // Pointer, read-return ownership and saturating collision counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r      <= {IW{1'b0}};
            rd_vld_r   <= 2'b00;
            owner_r[0] <= {IW{1'b0}};
            owner_r[1] <= {IW{1'b0}};
            coll_cnt_r <= {CNT_SIZE{1'b0}};
        end else begin
            if (grant_s[PORT_B]) begin
                ptr_r <= IW'(rr_inc(int'(win_s[PORT_B]), N));
            end else if (grant_s[PORT_A]) begin
                ptr_r <= IW'(rr_inc(int'(win_s[PORT_A]), N));
            end else begin
                ptr_r <= ptr_r;
            end
            for (int p = 0; p < 2; p++) begin
                rd_vld_r[p] <= grant_s[p] && !win_we_s[p];
                owner_r[p]  <= win_s[p];
            end
            if (coll_s && (coll_cnt_r != CNT_MAX)) begin
                coll_cnt_r <= coll_cnt_r + CNT_ONE;
            end else begin
                coll_cnt_r <= coll_cnt_r;
            end
        end
    end

    // Route each port's registered RAM data to the requester that owns it.
    always_comb begin
        bus.rvalid = {N{1'b0}};
        bus.rdata  = {(N*DATA_SIZE){1'b0}};
        for (int i = 0; i < N; i++) begin
            bus.rvalid[i] = (rd_vld_r[PORT_A] && (owner_r[PORT_A] == IW'(i))) ||
                            (rd_vld_r[PORT_B] && (owner_r[PORT_B] == IW'(i)));
            if (rd_vld_r[PORT_A] && (owner_r[PORT_A] == IW'(i))) begin
                bus.rdata[i*DATA_SIZE +: DATA_SIZE] = ram_dout_a;
            end else if (rd_vld_r[PORT_B] && (owner_r[PORT_B] == IW'(i))) begin
                bus.rdata[i*DATA_SIZE +: DATA_SIZE] = ram_dout_b;
            end else begin
                bus.rdata[i*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{1'b0}};
            end
        end
    end

    assign coll_cnt = coll_cnt_r;
endmodule
